// File: rtl/adder_pkg.sv
// Shared types and helpers for the chunked pipelined adder.
package adder_pkg;

  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} add_op_e;

  function automatic int chunk_w(input int data_w, input int num_stages);
    return data_w / num_stages;
  endfunction

endpackage

// File: rtl/adder_stage.sv
// One chunk slice: registers chunk sum, carry and valid; holds everything on stall.
module adder_stage #(
  parameter int CHUNK_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [CHUNK_W-1:0] i_a,
  input  logic [CHUNK_W-1:0] i_b,
  input  logic               i_c,
  input  logic               i_stall,
  input  logic               i_vld,
  output logic [CHUNK_W-1:0] o_s,
  output logic               o_c,
  output logic               o_vld
);

  // Data only moves with a valid token, so bubbles leave the last result in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_vld <= 1'b0;
      o_s   <= '0;
      o_c   <= 1'b0;
    end else if (!i_stall) begin
      o_vld <= i_vld;
      if (i_vld) {o_c, o_s} <= {1'b0, i_a} + {1'b0, i_b} + {{CHUNK_W{1'b0}}, i_c};
    end
  end

endmodule

// File: rtl/pipelined_adder.sv
// Add/subtract resolved one CHUNK_W slice per cycle, carry rippling stage to stage,
// with a global-stall valid/ready pipeline around it.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_STAGES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  c_in,
  input  add_op_e               op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  c_out,
  output logic                  overflow
);

  localparam int CW  = chunk_w(DATA_WIDTH, NUM_STAGES);
  localparam int MSB = DATA_WIDTH - 1;

  if (DATA_WIDTH % NUM_STAGES != 0) begin : g_cfg_chk
    $error("pipelined_adder: DATA_WIDTH must be a multiple of NUM_STAGES");
  end

  logic                                w_stall;
  logic [DATA_WIDTH-1:0]               w_b;
  logic [NUM_STAGES:0]                 w_c, w_v;
  logic [NUM_STAGES-1:0][CW-1:0]       w_ca, w_cb, w_s, w_sum_ch;
  logic                                r_amsb, r_bmsb;

  assign w_stall  = out_valid && !out_ready;
  assign in_ready = !w_stall;
  assign w_b      = (op == OP_SUB) ? ~b : b;
  assign w_c[0]   = (op == OP_SUB) ? ~c_in : c_in;
  assign w_v[0]   = in_valid;

  // w_v[k] is the valid token entering stage k; every register beside stage k loads on it.
  for (genvar j = 0; j < NUM_STAGES; j++) begin : g_lane
    adder_stage #(.CHUNK_W(CW)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_a     (w_ca[j]),
      .i_b     (w_cb[j]),
      .i_c     (w_c[j]),
      .i_stall (w_stall),
      .i_vld   (w_v[j]),
      .o_s     (w_s[j]),
      .o_c     (w_c[j+1]),
      .o_vld   (w_v[j+1])
    );

    if (j == 0) begin : g_head
      assign w_ca[0] = a[CW-1:0];
      assign w_cb[0] = w_b[CW-1:0];
    end else begin : g_skew
      logic [j-1:0][CW-1:0] r_a_sh, r_b_sh;
      always_ff @(posedge clk) begin
        if (!w_stall && w_v[0]) begin
          r_a_sh[0] <= a[j*CW +: CW];
          r_b_sh[0] <= w_b[j*CW +: CW];
        end
        for (int d = 1; d < j; d++) begin
          if (!w_stall && w_v[d]) begin
            r_a_sh[d] <= r_a_sh[d-1];
            r_b_sh[d] <= r_b_sh[d-1];
          end
        end
      end
      assign w_ca[j] = r_a_sh[j-1];
      assign w_cb[j] = r_b_sh[j-1];
    end

    if (j == NUM_STAGES - 1) begin : g_tail
      assign w_sum_ch[j] = w_s[j];
    end else begin : g_deskew
      localparam int D = NUM_STAGES - 1 - j;
      logic [D-1:0][CW-1:0] r_ds;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ds <= '0;
        end else begin
          if (!w_stall && w_v[j+1]) r_ds[0] <= w_s[j];
          for (int d = 1; d < D; d++) begin
            if (!w_stall && w_v[j+1+d]) r_ds[d] <= r_ds[d-1];
          end
        end
      end
      assign w_sum_ch[j] = r_ds[D-1];
    end
  end

  // Operand sign bits ride alongside the final stage for the overflow decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_amsb <= 1'b0;
      r_bmsb <= 1'b0;
    end else if (!w_stall && w_v[NUM_STAGES-1]) begin
      r_amsb <= w_ca[NUM_STAGES-1][CW-1];
      r_bmsb <= w_cb[NUM_STAGES-1][CW-1];
    end
  end

  assign out_valid = w_v[NUM_STAGES];
  assign sum       = w_sum_ch;
  assign c_out     = w_c[NUM_STAGES];
  assign overflow  = (r_amsb == r_bmsb) && (sum[MSB] != r_amsb);

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboarded random/directed bench over several (DATA_WIDTH, NUM_STAGES) configurations.
module tb_pipelined_adder;
  import adder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  function automatic void chk(input string n, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, act, req);
    end
  endfunction

  localparam int NCFG = 4;
  localparam int CFG_DW [NCFG] = '{8, 32, 16, 64};
  localparam int CFG_NS [NCFG] = '{2, 4, 1, 8};

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int DW = CFG_DW[g];
    localparam int NS = CFG_NS[g];
    localparam int CW = DW / NS;
    localparam logic [DW-1:0] ONES = '1;
    localparam logic [DW-1:0] MAXP = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] MINN = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [DW+1:0] SMAX = {3'b000, {(DW-1){1'b1}}};
    localparam logic signed [DW+1:0] SMIN = {3'b111, {(DW-1){1'b0}}};

    logic          rst_n, in_valid, in_ready, c_in, out_valid, out_ready, c_out, overflow;
    add_op_e       op;
    logic [DW-1:0] a, b, sum;
    bit            done = 1'b0;
    int            rdy_mode = 0;
    logic [DW+1:0] q[$];

    pipelined_adder #(.DATA_WIDTH(DW), .NUM_STAGES(NS)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .c_in(c_in), .op(op),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .c_out(c_out), .overflow(overflow)
    );

    function automatic void bchk(input string n, input logic [127:0] act, input logic [127:0] req);
      chk($sformatf("dw%0d_ns%0d_%s", DW, NS, n), act, req);
    endfunction

    // Reference: true integer result, carry/borrow and signed range test.
    function automatic logic [DW+1:0] model(input logic [DW-1:0] ma, input logic [DW-1:0] mb,
                                            input logic mci, input add_op_e mop);
      logic [DW:0]             u;
      logic signed [DW+1:0]    s;
      logic                    cy, ov;
      if (mop == OP_ADD) begin
        u  = {1'b0, ma} + {1'b0, mb} + {{DW{1'b0}}, mci};
        s  = $signed({ma[DW-1], ma[DW-1], ma}) + $signed({mb[DW-1], mb[DW-1], mb})
           + $signed({{(DW+1){1'b0}}, mci});
        cy = u[DW];
      end else begin
        u  = {1'b0, ma} - {1'b0, mb} - {{DW{1'b0}}, mci};
        s  = $signed({ma[DW-1], ma[DW-1], ma}) - $signed({mb[DW-1], mb[DW-1], mb})
           - $signed({{(DW+1){1'b0}}, mci});
        cy = !u[DW];
      end
      ov = (s > SMAX) || (s < SMIN);
      return {ov, cy, u[DW-1:0]};
    endfunction

    function automatic logic [DW-1:0] rnd_val();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      case ($urandom_range(0, 7))
        0:       return ONES;
        1:       return '0;
        2:       return MINN;
        3:       return MAXP;
        default: return r[DW-1:0];
      endcase
    endfunction

    task automatic send(input logic [DW-1:0] sa, input logic [DW-1:0] sb, input logic sci,
                        input add_op_e sop, input logic [DW+1:0] sexp, output int waits);
      logic acc, fin;
      a = sa; b = sb; c_in = sci; op = sop; in_valid = 1'b1;
      waits = 0; fin = 1'b0;
      while (!fin) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        if (acc) begin
          q.push_back(sexp);
          fin = 1'b1;
        end else begin
          waits++;
          if (waits > 200) begin
            bchk("accept_timeout", 128'(waits), 128'(0));
            fin = 1'b1;
          end
        end
      end
      #1;
    endtask

    task automatic send_rand(output int waits);
      logic [DW-1:0] ra, rb;
      logic          rci;
      add_op_e       rop;
      ra = rnd_val(); rb = rnd_val(); rci = 1'($urandom_range(0, 1));
      rop = add_op_e'($urandom_range(0, 1));
      send(ra, rb, rci, rop, model(ra, rb, rci, rop), waits);
    endtask

    task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
        @(posedge clk);
        #1;
      end
    endtask

    initial begin : ready_drv
      out_ready = 1'b1;
      forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
          0:       out_ready = 1'b1;
          1:       out_ready = ($urandom_range(0, 3) != 0);
          default: out_ready = 1'b0;
        endcase
      end
    end

    initial begin : mon
      forever begin
        @(negedge clk);
        if (rst_n === 1'b1) begin
          bchk("in_ready", 128'(in_ready), 128'(!(out_valid && !out_ready)));
          if (out_valid === 1'b1) begin
            if (q.size() == 0) bchk("spurious_out_valid", 128'(out_valid), 128'(0));
            else begin
              bchk("result", 128'({overflow, c_out, sum}), 128'(q[0]));
              if (out_ready) void'(q.pop_front());
            end
          end
        end
      end
    end

    initial begin : drv
      int            w, cnt;
      logic [DW-1:0] lowch, ha, hb;
      logic [DW:0]   tmp;
      logic          hci;
      add_op_e       hop;
      rst_n = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; op = OP_ADD;
      #2 rst_n = 1'b0;
      #1;
      bchk("rst_out_valid", 128'(out_valid), 128'(0));
      bchk("rst_sum", 128'(sum), 128'(0));
      bchk("rst_c_out", 128'(c_out), 128'(0));
      bchk("rst_overflow", 128'(overflow), 128'(0));
      bchk("rst_in_ready", 128'(in_ready), 128'(1));
      @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

      // single op latency
      send(DW'(3), DW'(4), 1'b0, OP_ADD, model(DW'(3), DW'(4), 1'b0, OP_ADD), w);
      in_valid = 1'b0;
      cnt = 0;
      while (out_valid !== 1'b1 && cnt < 50) begin
        @(posedge clk); #1; cnt++;
      end
      bchk("latency", 128'(cnt + 1), 128'(NS));
      idle(NS + 2);

      // directed corner cases, expected from the arithmetic rules directly
      lowch = '0; lowch[CW-1:0] = '1;
      tmp   = {1'b0, lowch} + (DW+1)'(2);
      send(ONES, DW'(1), 1'b0, OP_ADD, {1'b0, 1'b1, {DW{1'b0}}}, w);
      send(MAXP, DW'(1), 1'b0, OP_ADD, {1'b1, 1'b0, MINN}, w);
      send(lowch, DW'(1), 1'b1, OP_ADD, {1'b0, tmp[DW], tmp[DW-1:0]}, w);
      send(DW'(5), DW'(7), 1'b0, OP_SUB, {1'b0, 1'b0, ONES - DW'(1)}, w);
      send(MINN, DW'(1), 1'b0, OP_SUB, {1'b1, 1'b1, MAXP}, w);
      send(DW'(5), DW'(4), 1'b1, OP_SUB, {1'b0, 1'b1, {DW{1'b0}}}, w);
      send('0, '0, 1'b1, OP_ADD, {2'b00, DW'(1)}, w);
      idle(NS + 2);

      // back-to-back stream with a free consumer
      for (int i = 0; i < 8; i++) begin
        send_rand(w);
        bchk("stream_in_ready", 128'(w), 128'(0));
      end
      idle(NS + 2);

      // backpressure: fill, then hold an offered operand across a 3-cycle stall
      rdy_mode = 2;
      idle(2);
      for (int i = 0; i < NS; i++) begin
        send_rand(w);
        bchk("fill_accept", 128'(w), 128'(0));
      end
      ha = rnd_val(); hb = rnd_val(); hci = 1'b1; hop = OP_SUB;
      a = ha; b = hb; c_in = hci; op = hop; in_valid = 1'b1;
      repeat (3) begin
        @(negedge clk);
        bchk("stall_in_ready", 128'(in_ready), 128'(0));
        @(posedge clk); #1;
      end
      rdy_mode = 0;
      send(ha, hb, hci, hop, model(ha, hb, hci, hop), w);
      idle(NS + 3);

      // reset with results in flight
      send_rand(w);
      send_rand(w);
      rst_n = 1'b0;
      q.delete();
      in_valid = 1'b0;
      #1;
      bchk("midrst_out_valid", 128'(out_valid), 128'(0));
      bchk("midrst_sum", 128'(sum), 128'(0));
      bchk("midrst_c_out", 128'(c_out), 128'(0));
      bchk("midrst_overflow", 128'(overflow), 128'(0));
      @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
      idle(NS + 3);
      bchk("post_reset_out_valid", 128'(out_valid), 128'(0));

      // random traffic with random consumer backpressure and input gaps
      rdy_mode = 1;
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        send_rand(w);
      end
      rdy_mode = 0;
      in_valid = 1'b0;
      cnt = 0;
      while (q.size() != 0 && cnt < 300) begin
        @(posedge clk); #1; cnt++;
      end
      bchk("drain_empty", 128'(q.size()), 128'(0));
      done = 1'b1;
    end
  end

  initial begin : summary
    int cyc;
    cyc = 0;
    while (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done && g_cfg[3].done) && cyc < 20000) begin
      @(posedge clk);
      cyc++;
    end
    if (cyc >= 20000) begin
      checks++;
      failures++;
      $display("FAIL global_timeout cycles=%0d required_below=20000", cyc);
    end
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
